c499_key_loader: RTL and testbench
==================================

// Module: c499_key_loader
// PURPOSE
//  Loads the 32-bit unlock key for the locked c499 ECC core: 28 XOR key bits (X_1..X_28) and 4 mux-select bits (p1..p4).
//  Key arrives serially over a valid/ready handshake into a shadow register.
//  The shadow register is checked, then committed atomically to the registered key outputs.
//  Sits directly upstream of the locked core; x_key/p_key drive its key inputs combinationally.
// PARAMETERS
//  KEY_XOR_W  28     number of XOR key bits (x_key width)
//  KEY_MUX_W  4      number of mux key bits (p_key width)
//  CRC_POLY   8'h07  CRC-8 polynomial (only used with KEY_CRC_EN)
//  TIMEOUT    255    max idle cycles between accepted bits before abort (8-bit counter)
// PORTS
//  clk         in   1          sole clock, rising edge
//  rst_n       in   1          synchronous active-low reset
//  load_start  in   1          pulse: begin (or restart) a key load
//  key_clear   in   1          pulse: zeroize key, disarm
//  key_valid   in   1          serial bit valid
//  key_bit     in   1          serial key data
//  key_ready   out  1          loader accepts a bit this cycle
//  x_key       out  KEY_XOR_W  committed XOR key; x_key[0]=X_1 .. x_key[27]=X_28
//  p_key       out  KEY_MUX_W  committed mux key; p_key[0]=p1 .. p_key[3]=p4
//  key_armed   out  1          1 = committed key valid
//  load_busy   out  1          1 while in SHIFT/CRC/COMMIT
//  load_err    out  1          sticky error; cleared by load_start, key_clear or reset
// BEHAVIOUR
//  - Reset (rst_n=0 at a clk edge): all outputs 0; shadow, bit counter, CRC and timeout counter 0; state IDLE.
//  - States: IDLE, SHIFT, CRC, COMMIT, ERR. key_ready=1 only in SHIFT and CRC.
//  - Bit accepted on an edge where key_valid & key_ready. First accepted bit goes to shadow[0], bit n to shadow[n].
//    shadow[27:0] -> x_key, shadow[31:28] -> p_key.
//  - IDLE --load_start--> SHIFT: clear shadow, counters, CRC and load_err.
//  - SHIFT: after the 32nd accepted bit -> CRC (macro on) or COMMIT (macro off).
//  - COMMIT: lasts 1 cycle. At its closing edge: x_key/p_key <= shadow, key_armed <= 1, state -> IDLE.
//    Outputs therefore change 1 edge after the final handshake edge.
//  - ERR: lasts 1 cycle. load_err <= 1; x_key/p_key/key_armed keep previously committed values; state -> IDLE.
//  - Timeout: counter resets on each accepted bit and increments otherwise in SHIFT/CRC.
//    When it reaches TIMEOUT -> ERR.
//  - load_start while in SHIFT/CRC: restart the load exactly as from IDLE. Partial data is discarded; committed key untouched.
//  - key_clear: highest priority after reset, in any state.
//    Zeroizes x_key, p_key, shadow; key_armed <= 0, load_err <= 0; state -> IDLE.
//  - key_clear and load_start in the same cycle: key_clear wins; load_start is ignored.
//  - Committed key registers change only in COMMIT, on key_clear, or on reset. Never glitch during shifting.
// CONFIGURATION
//  KEY_CRC_EN defined:
//    - CRC-8 (CRC_POLY, init 8'h00, unreflected) is updated on each key bit in acceptance order.
//    - CRC state accepts 8 more bits, compared MSB-first: first received bit is checked against crc[7].
//    - All 8 bits match -> COMMIT. Any mismatch -> ERR.
//  KEY_CRC_EN undefined: no CRC state or logic; SHIFT goes straight to COMMIT after 32 bits.
// TESTING
//  1. Reset: rst_n=0 for 2 cycles -> x_key=0, p_key=0, key_armed=0, load_err=0, key_ready=0.
//  2. No CRC: load_start, 32 bits forming 32'h8000_000F, key_valid held high
//     -> x_key=28'h000000F, p_key=4'h8, key_armed=1 exactly 1 edge after the last bit.
//  3. CRC build: key 32'h0, CRC 8'h00 -> key_armed=1, load_err=0.
//     Same with CRC 8'h01 -> load_err=1 and previous key retained.
//  4. Timeout: after 10 bits, drop key_valid for 255 cycles -> load_err=1, state IDLE, committed key unchanged.
//  5. Restart/clear: load_start after 20 bits, then a full 32'hFFFF_FFFF load -> p_key=4'hF, x_key=28'hFFFFFFF.
//     Then key_clear together with load_start -> all key outputs 0, key_armed=0, load_busy=0.

Source files
------------

// File: rtl/c499_key_loader.sv
// c499_key_loader
//   Serial loader for the 32-bit unlock key of the locked c499 ECC core.
//   Bits arrive LSB-first over a valid/ready handshake into a shadow
//   register. When the load completes, the shadow is committed atomically
//   into the registered key outputs. The committed key registers move only
//   on commit, key_clear or reset, so the locked core never sees a
//   partially shifted key.
//
//   Optional feature: define KEY_CRC_EN to require an 8-bit CRC trailer
//   (CRC-8, poly CRC_POLY, init 0, unreflected, sent MSB-first) after the
//   key bits. A bad trailer aborts the load into the error state.
//
// Ports
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   load_start  pulse: begin or restart a key load
//   key_clear   pulse: zeroize the key and disarm (beats load_start)
//   key_valid   serial bit valid
//   key_bit     serial key data
//   key_ready   loader accepts a bit this cycle (SHIFT/CRC)
//   x_key       committed XOR key, x_key[0]=X_1
//   p_key       committed mux key, p_key[0]=p1
//   key_armed   committed key is valid
//   load_busy   load in progress (SHIFT/CRC/COMMIT)
//   load_err    sticky error, cleared by load_start, key_clear or reset

module c499_key_loader #(
    parameter int         KEY_XOR_W = 28,
    parameter int         KEY_MUX_W = 4,
    parameter logic [7:0] CRC_POLY  = 8'h07,
    parameter int         TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_start,
    input  logic                 key_clear,
    input  logic                 key_valid,
    input  logic                 key_bit,
    output logic                 key_ready,
    output logic [KEY_XOR_W-1:0] x_key,
    output logic [KEY_MUX_W-1:0] p_key,
    output logic                 key_armed,
    output logic                 load_busy,
    output logic                 load_err
);

    localparam int                KEY_W    = KEY_XOR_W + KEY_MUX_W;
    localparam int                CNT_W    = $clog2(KEY_W + 1);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(KEY_W - 1);
    // Transition fires on the idle edge that brings the counter to TIMEOUT.
    localparam logic [7:0]        TMO_LAST = 8'(TIMEOUT - 1);

`ifdef KEY_CRC_EN
    typedef enum logic [2:0] {IDLE, SHIFT, CRC, COMMIT, ERR} state_t;
`else
    typedef enum logic [2:0] {IDLE, SHIFT, COMMIT, ERR} state_t;
`endif

    state_t             state;
    logic [KEY_W-1:0]   shadow;
    logic [CNT_W-1:0]   bit_cnt;
    logic [7:0]         tmo_cnt;

`ifdef KEY_CRC_EN
    logic [7:0]         crc;
    logic [2:0]         crc_cnt;
    logic               crc_bad;
    logic               crc_fb;

    // Feedback for the serial CRC-8 update.
    assign crc_fb = crc[7] ^ key_bit;
`else
    logic unused_crc_poly;
    assign unused_crc_poly = ^CRC_POLY;
`endif

    // Pure decodes of the state register.
`ifdef KEY_CRC_EN
    assign key_ready = (state == SHIFT) || (state == CRC);
    assign load_busy = (state == SHIFT) || (state == CRC) || (state == COMMIT);
`else
    assign key_ready = (state == SHIFT);
    assign load_busy = (state == SHIFT) || (state == COMMIT);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            shadow    <= '0;
            bit_cnt   <= '0;
            tmo_cnt   <= '0;
            x_key     <= '0;
            p_key     <= '0;
            key_armed <= 1'b0;
            load_err  <= 1'b0;
`ifdef KEY_CRC_EN
            crc       <= '0;
            crc_cnt   <= '0;
            crc_bad   <= 1'b0;
`endif
        end else if (key_clear) begin
            state     <= IDLE;
            shadow    <= '0;
            bit_cnt   <= '0;
            tmo_cnt   <= '0;
            x_key     <= '0;
            p_key     <= '0;
            key_armed <= 1'b0;
            load_err  <= 1'b0;
`ifdef KEY_CRC_EN
            crc       <= '0;
            crc_cnt   <= '0;
            crc_bad   <= 1'b0;
`endif
        end else if (load_start && (state == IDLE || key_ready)) begin
            // Start or restart: partial data is dropped, committed key kept.
            state     <= SHIFT;
            shadow    <= '0;
            bit_cnt   <= '0;
            tmo_cnt   <= '0;
            load_err  <= 1'b0;
`ifdef KEY_CRC_EN
            crc       <= '0;
            crc_cnt   <= '0;
            crc_bad   <= 1'b0;
`endif
        end else begin
            case (state)
                SHIFT: begin
                    if (key_valid) begin
                        // Shift in from the top: after KEY_W bits the first
                        // accepted bit sits in shadow[0].
                        shadow  <= {key_bit, shadow[KEY_W-1:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        tmo_cnt <= '0;
`ifdef KEY_CRC_EN
                        crc     <= {crc[6:0], 1'b0} ^ (crc_fb ? CRC_POLY : 8'h00);
                        if (bit_cnt == LAST_BIT)
                            state <= CRC;
`else
                        if (bit_cnt == LAST_BIT)
                            state <= COMMIT;
`endif
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                        if (tmo_cnt == TMO_LAST)
                            state <= ERR;
                    end
                end
`ifdef KEY_CRC_EN
                CRC: begin
                    if (key_valid) begin
                        // Trailer is compared MSB-first; shifting the CRC left
                        // keeps the bit under test in crc[7].
                        crc     <= {crc[6:0], 1'b0};
                        crc_cnt <= crc_cnt + 3'd1;
                        tmo_cnt <= '0;
                        if (key_bit != crc[7])
                            crc_bad <= 1'b1;
                        if (crc_cnt == 3'd7)
                            state <= (crc_bad || (key_bit != crc[7])) ? ERR : COMMIT;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                        if (tmo_cnt == TMO_LAST)
                            state <= ERR;
                    end
                end
`endif
                COMMIT: begin
                    x_key     <= shadow[KEY_XOR_W-1:0];
                    p_key     <= shadow[KEY_W-1:KEY_XOR_W];
                    key_armed <= 1'b1;
                    state     <= IDLE;
                end
                ERR: begin
                    load_err <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_c499_key_loader.sv
// Directed bench for c499_key_loader: table of full key loads plus
// hand-written sequences for timeout, restart and clear corner cases.
// With KEY_CRC_EN defined, loads append the CRC-8 trailer and the CRC
// pass/fail sequence is exercised.

module tb_c499_key_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_start, key_clear, key_valid, key_bit;
    logic        key_ready, key_armed, load_busy, load_err;
    logic [27:0] x_key;
    logic [3:0]  p_key;

    int n_vec = 0;
    int n_err = 0;

    c499_key_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .key_clear  (key_clear),
        .key_valid  (key_valid),
        .key_bit    (key_bit),
        .key_ready  (key_ready),
        .x_key      (x_key),
        .p_key      (p_key),
        .key_armed  (key_armed),
        .load_busy  (load_busy),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] key;
        logic [27:0] x;
        logic [3:0]  p;
    } vec_t;

    vec_t tbl[5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference CRC-8 (poly 0x07, init 0) over the key bits in send order.
    function automatic logic [7:0] crc8(input logic [31:0] k);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 0; i < 32; i++) begin
            if (c[7] ^ k[i]) c = {c[6:0], 1'b0} ^ 8'h07;
            else             c = {c[6:0], 1'b0};
        end
        return c;
    endfunction

    // Pulse load_start, then send nbits of k LSB-first with valid held high.
    // Full loads in the CRC build append the trailer byte crcb MSB-first.
    task automatic load_key(input logic [31:0] k, input int nbits, input logic [7:0] crcb,
                            input logic [27:0] prev_x, input logic [3:0] prev_p);
        logic [7:0] cb;
        cb = crcb;
        key_valid  = 1'b0;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            key_valid = 1'b1;
            key_bit   = k[i];
            tick();
            if (i == 15) begin
                check("mid_shift_x", 32'(x_key), 32'(prev_x));
                check("mid_shift_p", 32'(p_key), 32'(prev_p));
            end
        end
`ifdef KEY_CRC_EN
        if (nbits == 32) begin
            for (int j = 7; j >= 0; j--) begin
                key_valid = 1'b1;
                key_bit   = cb[j];
                tick();
            end
        end
`else
        if (cb != 8'h00) key_bit = 1'b0;
`endif
        key_valid = 1'b0;
        key_bit   = 1'b0;
    endtask

    logic [27:0] px;
    logic [3:0]  pp;

    initial begin
        tbl[0] = '{32'h8000_000F, 28'h000_000F, 4'h8};
        tbl[1] = '{32'h1234_5678, 28'h234_5678, 4'h1};
        tbl[2] = '{32'hA5A5_A5A5, 28'h5A5_A5A5, 4'hA};
        tbl[3] = '{32'h0000_0000, 28'h000_0000, 4'h0};
        tbl[4] = '{32'h7FFF_FFF0, 28'hFFF_FFF0, 4'h7};

        rst_n = 1'b0; load_start = 1'b0; key_clear = 1'b0;
        key_valid = 1'b0; key_bit = 1'b0;
        tick();
        tick();
        check("rst_x_key",     32'(x_key), 32'h0);
        check("rst_p_key",     32'(p_key), 32'h0);
        check("rst_key_armed", 32'(key_armed), 32'h0);
        check("rst_load_err",  32'(load_err), 32'h0);
        check("rst_key_ready", 32'(key_ready), 32'h0);
        check("rst_load_busy", 32'(load_busy), 32'h0);
        rst_n = 1'b1;
        tick();

        px = 28'h0; pp = 4'h0;
        for (int i = 0; i < 5; i++) begin
            load_key(tbl[i].key, 32, crc8(tbl[i].key), px, pp);
            // In COMMIT: outputs must not move until the next edge.
            check("pre_commit_x",     32'(x_key), 32'(px));
            check("pre_commit_armed", 32'(key_armed), (i == 0) ? 32'h0 : 32'h1);
            check("pre_commit_busy",  32'(load_busy), 32'h1);
            tick();
            check("commit_x",     32'(x_key), 32'(tbl[i].x));
            check("commit_p",     32'(p_key), 32'(tbl[i].p));
            check("commit_armed", 32'(key_armed), 32'h1);
            check("commit_err",   32'(load_err), 32'h0);
            check("commit_busy",  32'(load_busy), 32'h0);
            check("commit_ready", 32'(key_ready), 32'h0);
            px = tbl[i].x; pp = tbl[i].p;
        end

`ifdef KEY_CRC_EN
        load_key(32'h0, 32, 8'h00, px, pp);
        tick();
        check("crc_ok_armed", 32'(key_armed), 32'h1);
        check("crc_ok_err",   32'(load_err), 32'h0);
        check("crc_ok_x",     32'(x_key), 32'h0);
        px = 28'h0; pp = 4'h0;
        load_key(32'h1234_5678, 32, crc8(32'h1234_5678), px, pp);
        tick();
        px = 28'h234_5678; pp = 4'h1;
        load_key(32'h0, 32, 8'h01, px, pp);
        tick();
        check("crc_bad_err",   32'(load_err), 32'h1);
        check("crc_bad_x",     32'(x_key), 32'(px));
        check("crc_bad_p",     32'(p_key), 32'(pp));
        check("crc_bad_armed", 32'(key_armed), 32'h1);
`endif

        // Timeout: 10 bits, then valid low. The 255th idle edge enters ERR,
        // the following edge sets load_err.
        load_key(32'h0000_03FF, 10, 8'h00, px, pp);
        repeat (254) tick();
        check("tmo_254_busy", 32'(load_busy), 32'h1);
        check("tmo_254_err",  32'(load_err), 32'h0);
        tick();
        check("tmo_255_ready", 32'(key_ready), 32'h0);
        tick();
        check("tmo_err",   32'(load_err), 32'h1);
        check("tmo_busy",  32'(load_busy), 32'h0);
        check("tmo_x",     32'(x_key), 32'(px));
        check("tmo_p",     32'(p_key), 32'(pp));
        check("tmo_armed", 32'(key_armed), 32'h1);

        // load_start clears the sticky error.
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        check("start_clr_err",  32'(load_err), 32'h0);
        check("start_busy",     32'(load_busy), 32'h1);

        // Restart mid-load, then a full all-ones key.
        load_key(32'h000A_5A5A, 20, 8'h00, px, pp);
        load_key(32'hFFFF_FFFF, 32, crc8(32'hFFFF_FFFF), px, pp);
        tick();
        check("restart_x",     32'(x_key), 32'hFFF_FFFF);
        check("restart_p",     32'(p_key), 32'hF);
        check("restart_armed", 32'(key_armed), 32'h1);

        // key_clear wins over a simultaneous load_start.
        key_clear = 1'b1; load_start = 1'b1;
        tick();
        key_clear = 1'b0; load_start = 1'b0;
        check("clr_x",     32'(x_key), 32'h0);
        check("clr_p",     32'(p_key), 32'h0);
        check("clr_armed", 32'(key_armed), 32'h0);
        check("clr_busy",  32'(load_busy), 32'h0);
        check("clr_ready", 32'(key_ready), 32'h0);
        tick();
        check("clr_busy_after", 32'(load_busy), 32'h0);

        // key_clear in the middle of a shift aborts the load.
        load_key(32'h8000_000F, 32, crc8(32'h8000_000F), 28'h0, 4'h0);
        tick();
        load_key(32'h1234_5678, 5, 8'h00, 28'h000_000F, 4'h8);
        key_clear = 1'b1;
        tick();
        key_clear = 1'b0;
        check("midclr_busy",  32'(load_busy), 32'h0);
        check("midclr_x",     32'(x_key), 32'h0);
        check("midclr_p",     32'(p_key), 32'h0);
        check("midclr_armed", 32'(key_armed), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
